keypad_scan: RTL and testbench
==============================

// Module: keypad_scan
// PURPOSE
//  Input-side twin of the multiplexed 4-digit display scanner. Drives a 4x4 matrix
//  keypad one column at a time with active-low strobes, samples the active-low rows,
//  debounces one key and returns its 4-bit hex code with a one-cycle valid pulse.
//  Sits between board keypad pins and game/music control logic.
// PARAMETERS
//  SCAN_DIV      16    clk cycles each column stays strobed (min 4)
//  DEBOUNCE_CNT  1000  consecutive stable clk cycles to accept a press or release
// PORTS
//  clk        in   1  system clock
//  rst_n      in   1  asynchronous reset, active-low
//  row_n      in   4  keypad rows, active-low, externally pulled up, asynchronous
//  col_n      out  4  column strobes, active-low, exactly one bit low at all times
//  key_code   out  4  code of last accepted key = {row[1:0], col[1:0]}
//  key_valid  out  1  one-cycle pulse when a debounced press is accepted
//  key_held   out  1  high from acceptance until release is debounced
// BEHAVIOUR
//  Reset (async, rst_n=0): col_n=4'b1110, key_code=0, key_valid=0, key_held=0,
//   state=SCAN, all counters 0, synchronizer FFs=4'b1111.
//  row_n passes a 2-FF synchronizer; all logic uses the synchronized rows (rs).
//  Column index c cycles 0,1,2,3,0; col_n = ~(1<<c). Dwell counter counts
//   0..SCAN_DIV-1; rs is evaluated only at count SCAN_DIV-1, then c advances.
//  Row pick: lowest-index low bit of rs wins (row 0 highest priority).
//  States:
//   SCAN     - at dwell end: rs==4'hF -> advance c; else latch r, freeze c,
//              clear debounce counter -> DEBOUNCE.
//   DEBOUNCE - each cycle: rs bit r low -> count++; bit r high -> SCAN, advance c,
//              no output. count reaches DEBOUNCE_CNT-1 -> key_code={r,c},
//              key_valid=1 for exactly that one cycle, key_held=1 -> HELD.
//   HELD     - c frozen; rs bit r high -> clear counter -> RELEASE.
//   RELEASE  - rs bit r high -> count++; low -> HELD (no new pulse).
//              count reaches DEBOUNCE_CNT-1 -> key_held=0, advance c -> SCAN.
//  Latency: press stable from cycle t -> key_valid at t+2 (sync) + remaining dwell
//   + DEBOUNCE_CNT cycles.
//  Other keys pressed while in DEBOUNCE/HELD/RELEASE are ignored (no rollover).
//  key_code holds its value until the next accepted press.
//  Counters sized $clog2 of their parameter; wrap never occurs (bounded by states).
//  rst_n asserted mid-press: immediate return to reset values; a key still held
//   after reset is re-detected and re-debounced, generating a fresh key_valid.
// STRUCTURE
//  keypad_defs.vh (shared `define header): state encodings SCAN=2'd0,
//   DEBOUNCE=2'd1, HELD=2'd2, RELEASE=2'd3; COL_IDLE=4'b1111; column strobe table.
//  One sub-module: kp_stable_cnt - clear/enable counter with terminal-count flag
//   at DEBOUNCE_CNT-1, shared by DEBOUNCE and RELEASE.
//  Top holds synchronizer, dwell counter, column index, FSM, output registers.
// TESTING (SCAN_DIV=4, DEBOUNCE_CNT=8)
//  1 Reset, no keys: col_n walks 1110,1101,1011,0111,1110 every 4 cycles;
//    key_valid never asserts; key_held=0.
//  2 Hold row 2 low while col 1 strobed: col_n freezes at 1101, single key_valid
//    pulse with key_code=4'h9, key_held=1 until release + 8 cycles.
//  3 Bounce: row 0 low 5 cycles then high, on col 3 -> no key_valid, scan
//    resumes at col 0.
//  4 Rows 1 and 3 low together on col 2 -> key_code=4'h6 (row 1 wins), one pulse.
//  5 Release glitch: in HELD drop row high 3 cycles then low again -> stays
//    HELD, no second pulse; true release -> key_held falls after 8 stable cycles.
//  6 Assert rst_n=0 during HELD -> outputs to reset values same cycle; key still
//    down after rst_n=1 -> new key_valid with same code.

Source files
------------

// File: rtl/keypad_scan_pkg.sv
// Shared definitions for the keypad scanner.
//   kp_state_e  : scanner FSM states (SCAN, DEBOUNCE, HELD, RELEASE)
//   ROW_IDLE    : synchronized row value with no key down (rows pulled up)
//   col_strobe  : column index -> active-low strobe pattern
//   row_pick    : lowest-index low row wins (row 0 has highest priority)
package keypad_scan_pkg;

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HELD     = 2'd2,
    ST_RELEASE  = 2'd3
  } kp_state_e;

  localparam logic [3:0] ROW_IDLE = 4'b1111;

  function automatic logic [3:0] col_strobe(input logic [1:0] c);
    col_strobe = ~(4'b0001 << c);
  endfunction

  function automatic logic [1:0] row_pick(input logic [3:0] rows);
    if (!rows[0])      row_pick = 2'd0;
    else if (!rows[1]) row_pick = 2'd1;
    else if (!rows[2]) row_pick = 2'd2;
    else               row_pick = 2'd3;
  endfunction

endpackage

// File: rtl/keypad_scan_if.sv
// Keypad pin and key-event bundle.
//   row_n     : keypad rows, active-low, asynchronous
//   col_n     : column strobes, active-low, one bit low at a time
//   key_code  : {row, col} of the last accepted key
//   key_valid : one-cycle pulse per accepted press; no back-pressure, the
//               consumer must take key_code in the cycle key_valid is high
//   key_held  : high from acceptance until the release is debounced
// master = scanner side, slave = board/consumer side.
interface keypad_scan_if;
  logic [3:0] row_n;
  logic [3:0] col_n;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  modport master (input row_n, output col_n, key_code, key_valid, key_held);
  modport slave  (output row_n, input col_n, key_code, key_valid, key_held);
endinterface

// File: rtl/keypad_scan_stable_cnt.sv
// kp_stable_cnt: clear/enable counter flagging DEBOUNCE_CNT-1 consecutive
// enabled cycles. Shared by the press and release debounce phases.
//   clk, rst_n : clock, async active-low reset
//   clr        : synchronous clear (priority over en)
//   en         : count this cycle
//   tc         : count == DEBOUNCE_CNT-1
module kp_stable_cnt #(
  parameter int DEBOUNCE_CNT = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);
  localparam int W = (DEBOUNCE_CNT > 1) ? $clog2(DEBOUNCE_CNT) : 1;

  logic [W-1:0] cnt;

  assign tc = (cnt == W'(DEBOUNCE_CNT - 1));

  // Holds at terminal count; the FSM always leaves the phase there anyway.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          cnt <= '0;
    else if (clr)        cnt <= '0;
    else if (en && !tc)  cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/keypad_scan.sv
// keypad_scan: 4x4 matrix keypad scanner with debounce.
// Strobes one column at a time (active-low), samples the synchronized rows at
// the end of each column dwell, debounces one key and reports its code.
//   clk, rst_n : clock, async active-low reset
//   kp         : keypad_scan_if.master (row_n in; col_n, key_code,
//                key_valid, key_held out)
//   dbg_state  : current FSM state
module keypad_scan
  import keypad_scan_pkg::*;
#(
  parameter int SCAN_DIV     = 16,
  parameter int DEBOUNCE_CNT = 1000
) (
  input  logic             clk,
  input  logic             rst_n,
  keypad_scan_if.master    kp,
  output kp_state_e        dbg_state
);
  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  kp_state_e   state, next_state;
  logic [3:0]  sync1, rs;
  logic [DW-1:0] dwell;
  logic [1:0]  col, row_sel;
  logic [3:0]  key_code;
  logic        key_valid, key_held;

  logic dwell_end, row_hit, tc;
  logic col_adv, latch_row, cnt_clr, cnt_en, accept, released;

  assign dwell_end = (dwell == DW'(SCAN_DIV - 1));
  assign row_hit   = ~rs[row_sel];   // latched row still pulled low

  kp_stable_cnt #(.DEBOUNCE_CNT(DEBOUNCE_CNT)) u_stable (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .tc    (tc)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_SCAN;
    else        state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      ST_SCAN:     if (dwell_end && rs != ROW_IDLE) next_state = ST_DEBOUNCE;
      ST_DEBOUNCE: if (!row_hit)                    next_state = ST_SCAN;
                   else if (tc)                     next_state = ST_HELD;
      ST_HELD:     if (!row_hit)                    next_state = ST_RELEASE;
      ST_RELEASE:  if (row_hit)                     next_state = ST_HELD;
                   else if (tc)                     next_state = ST_SCAN;
      default:                                      next_state = ST_SCAN;
    endcase
  end

  // Control outputs
  always_comb begin
    col_adv   = 1'b0;
    latch_row = 1'b0;
    cnt_clr   = 1'b0;
    cnt_en    = 1'b0;
    accept    = 1'b0;
    released  = 1'b0;
    case (state)
      ST_SCAN: begin
        col_adv   = dwell_end && (rs == ROW_IDLE);
        latch_row = dwell_end && (rs != ROW_IDLE);
        cnt_clr   = latch_row;
      end
      ST_DEBOUNCE: begin
        col_adv = !row_hit;          // bounce: give up, move to next column
        cnt_en  = row_hit;
        accept  = row_hit && tc;
      end
      ST_HELD: begin
        cnt_clr = !row_hit;
      end
      ST_RELEASE: begin
        cnt_en   = !row_hit;
        released = !row_hit && tc;
        col_adv  = released;
      end
      default: ;
    endcase
  end

  // Synchronizer, dwell timer, column index and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1     <= ROW_IDLE;
      rs        <= ROW_IDLE;
      dwell     <= '0;
      col       <= 2'd0;
      row_sel   <= 2'd0;
      key_code  <= 4'd0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      sync1 <= kp.row_n;
      rs    <= sync1;
      // Dwell only runs while scanning, so a resumed scan gets a full window.
      if (state == ST_SCAN && !dwell_end) dwell <= dwell + 1'b1;
      else                                dwell <= '0;
      if (col_adv)   col     <= col + 2'd1;
      if (latch_row) row_sel <= row_pick(rs);
      key_valid <= accept;
      if (accept) begin
        key_code <= {row_sel, col};
        key_held <= 1'b1;
      end else if (released) begin
        key_held <= 1'b0;
      end
    end
  end

  assign kp.col_n     = col_strobe(col);
  assign kp.key_code  = key_code;
  assign kp.key_valid = key_valid;
  assign kp.key_held  = key_held;
  assign dbg_state    = state;

endmodule

// File: tb/tb_keypad_scan.sv
module tb_keypad_scan;
  import keypad_scan_pkg::*;

  localparam int SCAN_DIV = 4;
  localparam int DC       = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  keypad_scan_if kp ();
  kp_state_e dbg_state;

  keypad_scan #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_CNT(DC)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .kp        (kp),
    .dbg_state (dbg_state)
  );

  // ---------------- physical keypad ----------------
  // pressed[r*4+c] closes the switch between row r and column c.
  logic [15:0] pressed = 16'h0;
  logic [3:0]  rows;
  always_comb begin
    rows = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !kp.col_n[c]) rows[r] = 1'b0;
  end
  assign kp.row_n = rows;

  // ---------------- counters ----------------
  int tests = 0;
  int fails = 0;
  int valid_seen = 0;
  bit chk_on = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Rows reach the decision logic two clocks late. A key is looked for once per
  // SCAN_DIV-cycle column window; once found it must stay down DC consecutive
  // cycles to be accepted and then stay up DC+1 consecutive cycles to count as
  // released (the first "up" cycle arms the release timer).
  logic [3:0] hist[$];
  int  m_col, m_tick, m_row, m_run;
  bit  m_held, m_valid;
  logic [3:0] m_code;

  task automatic model_reset();
    hist = {4'hF, 4'hF};
    m_col = 0; m_tick = 0; m_row = -1; m_run = 0;
    m_held = 0; m_valid = 0; m_code = 4'h0;
  endtask

  task automatic model_step(input logic [3:0] rin);
    logic [3:0] seen;
    seen = hist.pop_front();
    hist.push_back(rin);
    m_valid = 0;
    if (m_row < 0) begin
      if (m_tick == SCAN_DIV - 1) begin
        m_tick = 0;
        if (seen == 4'hF) m_col = (m_col + 1) % 4;
        else begin
          for (int i = 3; i >= 0; i--) if (!seen[i]) m_row = i;
          m_run = 0;
        end
      end else m_tick++;
    end else if (!m_held) begin
      if (seen[m_row]) begin
        m_row = -1;
        m_col = (m_col + 1) % 4;
      end else begin
        m_run++;
        if (m_run == DC) begin
          m_valid = 1;
          m_code  = 4'(m_row * 4 + m_col);
          m_held  = 1;
          m_run   = 0;
        end
      end
    end else begin
      if (seen[m_row]) begin
        m_run++;
        if (m_run == DC + 1) begin
          m_held = 0;
          m_row  = -1;
          m_col  = (m_col + 1) % 4;
          m_run  = 0;
        end
      end else m_run = 0;
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else        model_step(kp.row_n);
    end
  end

  // ---------------- scoreboard compare ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (kp.key_valid) valid_seen++;
      if (chk_on) begin
        logic [3:0] exp_col;
        exp_col = 4'hF;
        exp_col[m_col] = 1'b0;
        tests++;
        if (kp.col_n !== exp_col || kp.key_valid !== m_valid ||
            kp.key_held !== m_held || kp.key_code !== m_code) begin
          fails++;
          $display("FAIL cycle_cmp at %0t: col_n=%b/%b valid=%b/%b held=%b/%b code=%h/%h (dut/model)",
                   $time, kp.col_n, exp_col, kp.key_valid, m_valid,
                   kp.key_held, m_held, kp.key_code, m_code);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_col(input logic [3:0] target);
    int n;
    n = 0;
    while (kp.col_n !== target && n < 64) begin @(negedge clk); n++; end
    check("wait_col_timeout", (n < 64), 1);
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    while (kp.key_valid !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    check("wait_valid_timeout", (n < 200), 1);
  endtask

  task automatic wait_release();
    int n;
    n = 0;
    while (kp.key_held !== 1'b0 && n < 200) begin @(negedge clk); n++; end
    check("wait_release_timeout", (n < 200), 1);
  endtask

  // ---------------- stimulus ----------------
  logic [3:0] walk [5];
  int v0, k, dur, bnc;

  initial begin
    walk[0] = 4'b1110; walk[1] = 4'b1101; walk[2] = 4'b1011;
    walk[3] = 4'b0111; walk[4] = 4'b1110;
    repeat (3) @(negedge clk);
    chk_on = 1'b1;

    // 1: idle scan after reset
    check("reset_col_n", kp.col_n, 4'b1110);
    check("reset_code", kp.key_code, 4'h0);
    check("reset_held", kp.key_held, 1'b0);
    check("reset_state", dbg_state, ST_SCAN);
    rst_n = 1'b1;
    for (int i = 1; i < 5; i++) begin
      repeat (SCAN_DIV) @(negedge clk);
      check("idle_walk", kp.col_n, walk[i]);
    end
    check("idle_no_valid", valid_seen, 0);

    // 2: key row 2 / col 1
    wait_col(4'b1101);
    pressed[2*4+1] = 1'b1;
    v0 = valid_seen;
    wait_valid();
    check("s2_code", kp.key_code, 4'h9);
    check("s2_col_frozen", kp.col_n, 4'b1101);
    check("s2_held", kp.key_held, 1'b1);
    repeat (12) @(negedge clk);
    check("s2_one_pulse", valid_seen - v0, 1);
    pressed = 16'h0;
    wait_release();

    // 3: bounce on col 3
    wait_col(4'b0111);
    v0 = valid_seen;
    pressed[0*4+3] = 1'b1;
    repeat (5) @(negedge clk);
    pressed = 16'h0;
    repeat (20) @(negedge clk);
    check("s3_no_valid", valid_seen - v0, 0);

    // 4: rows 1 and 3 together on col 2
    wait_col(4'b1011);
    v0 = valid_seen;
    pressed[1*4+2] = 1'b1;
    pressed[3*4+2] = 1'b1;
    wait_valid();
    check("s4_code", kp.key_code, 4'h6);
    repeat (10) @(negedge clk);
    check("s4_one_pulse", valid_seen - v0, 1);
    pressed = 16'h0;
    wait_release();

    // 5: release glitch
    wait_col(4'b1110);
    v0 = valid_seen;
    pressed[3*4+0] = 1'b1;
    wait_valid();
    check("s5_code", kp.key_code, 4'hC);
    repeat (5) @(negedge clk);
    pressed = 16'h0;
    repeat (3) @(negedge clk);
    pressed[3*4+0] = 1'b1;
    repeat (15) @(negedge clk);
    check("s5_still_held", kp.key_held, 1'b1);
    check("s5_one_pulse", valid_seen - v0, 1);
    pressed = 16'h0;
    wait_release();

    // 6: reset while held, key stays down
    wait_col(4'b1110);
    pressed[0] = 1'b1;
    wait_valid();
    check("s6_code", kp.key_code, 4'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("s6_rst_held", kp.key_held, 1'b0);
    check("s6_rst_col", kp.col_n, 4'b1110);
    check("s6_rst_state", dbg_state, ST_SCAN);
    @(negedge clk);
    rst_n = 1'b1;
    v0 = valid_seen;
    wait_valid();
    check("s6_redetect_code", kp.key_code, 4'h0);
    check("s6_redetect_pulse", valid_seen - v0, 1);
    pressed = 16'h0;
    wait_release();

    // random presses with bounce, checked by the model every cycle
    for (int it = 0; it < 40; it++) begin
      k   = $urandom_range(0, 15);
      dur = $urandom_range(1, 40);
      bnc = $urandom_range(0, 6);
      for (int b = 0; b < bnc; b++) begin
        pressed[k] = ~pressed[k];
        @(negedge clk);
      end
      pressed[k] = 1'b1;
      if ($urandom_range(0, 3) == 0) pressed[$urandom_range(0, 15)] = 1'b1;
      repeat (dur) @(negedge clk);
      bnc = $urandom_range(0, 6);
      for (int b = 0; b < bnc; b++) begin
        pressed[k] = ~pressed[k];
        @(negedge clk);
      end
      pressed = 16'h0;
      repeat ($urandom_range(1, 30)) @(negedge clk);
    end
    wait_release();
    repeat (10) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
